// File: rtl/morse_pkg.sv
// Shared definitions for the Morse sidetone generator: symbol codes,
// sequencer state encoding and per-symbol unit counts.
package morse_pkg;

  localparam logic [1:0] SYM_DOT  = 2'd0;
  localparam logic [1:0] SYM_DASH = 2'd1;
  localparam logic [1:0] SYM_LGAP = 2'd2;
  localparam logic [1:0] SYM_WGAP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Units of sounding tone at the start of a symbol.
  function automatic logic [2:0] tone_units(input logic [1:0] s);
    logic [2:0] n;
    case (s)
      SYM_DOT:  n = 3'd1;
      SYM_DASH: n = 3'd3;
      default:  n = 3'd0;
    endcase
    return n;
  endfunction

  // Total units a symbol occupies, tone plus trailing silence.
  function automatic logic [2:0] total_units(input logic [1:0] s);
    logic [2:0] n;
    case (s)
      SYM_DOT:  n = 3'd2;
      SYM_DASH: n = 3'd4;
      SYM_LGAP: n = 3'd3;
      default:  n = 3'd7;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/morse_tone_gen_tone_pwm.sv
// Square-tone generator: free-running period counter with a duty compare.
// The output register is loaded from the counter value of the coming cycle,
// so beep in a cycle matches that cycle's counter and gate.
module tone_pwm #(
  parameter int unsigned PW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic          gate,
  input  logic [PW-1:0] period,
  input  logic [PW-1:0] high,
  output logic          beep
);

  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_inc;
  logic [PW-1:0] cnt_next;
  logic          beep_next;

  // Next counter value and next beep level.
  always_comb begin
    cnt_inc  = cnt + 1'b1;
    cnt_next = cnt_inc;
    if (restart || (cnt_inc >= period)) cnt_next = '0;
    beep_next = gate && (period != '0) && (cnt_next < high);
  end

  // Counter and registered buzzer drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      beep <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      beep <= beep_next;
    end
  end

endmodule

// File: rtl/morse_tone_gen.sv
// Morse element sequencer with programmable sidetone. Accepts one symbol
// per handshake, times it in units of a latched unit length and drives
// the buzzer through tone_pwm.
module morse_tone_gen #(
  parameter int unsigned PW = 20,
  parameter int unsigned UW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [PW-1:0] tone_period,
  input  logic [PW-1:0] tone_high,
  input  logic [UW-1:0] unit_len,
  input  logic          sym_valid,
  input  logic [1:0]    sym,
  output logic          sym_ready,
  output logic          beep,
  output logic          busy,
  output logic          done
);

  import morse_pkg::*;

  state_t        state;
  state_t        next_state;
  logic [UW-1:0] cyc_cnt;
  logic [2:0]    unit_cnt;
  logic [2:0]    unit_next;
  logic          unit_end;
  logic          accept;
  logic [PW-1:0] lat_period;
  logic [PW-1:0] lat_high;
  logic [UW-1:0] lat_unit;
  logic [1:0]    lat_sym;
  logic [PW-1:0] pwm_period;
  logic [PW-1:0] pwm_high;

  assign accept    = sym_valid && sym_ready;
  assign unit_end  = (cyc_cnt == lat_unit - 1'b1);
  assign unit_next = unit_cnt + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; disable forces IDLE.
  always_comb begin
    next_state = state;
    if (!en) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) next_state = (tone_units(sym) != 3'd0) ? ST_TONE : ST_GAP;
        ST_TONE: if (unit_end && (unit_next == tone_units(lat_sym))) next_state = ST_GAP;
        ST_GAP:  if (unit_end && (unit_next == total_units(lat_sym))) next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Handshake and status outputs.
  always_comb begin
    sym_ready = (state == ST_IDLE) && en && !rst;
    busy      = (state != ST_IDLE);
    done      = en && (state == ST_GAP) && unit_end && (unit_next == total_units(lat_sym));
  end

  // Cycle-within-unit and elapsed-unit counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      unit_cnt <= '0;
    end else if (!en || (state == ST_IDLE)) begin
      cyc_cnt  <= '0;
      unit_cnt <= '0;
    end else if (unit_end) begin
      cyc_cnt  <= '0;
      unit_cnt <= unit_next;
    end else begin
      cyc_cnt  <= cyc_cnt + 1'b1;
    end
  end

  // Capture configuration and symbol at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_period <= '0;
      lat_high   <= '0;
      lat_unit   <= {{(UW-1){1'b0}}, 1'b1};
      lat_sym    <= SYM_DOT;
    end else if (accept) begin
      lat_period <= tone_period;
      lat_high   <= tone_high;
      lat_unit   <= (unit_len == '0) ? {{(UW-1){1'b0}}, 1'b1} : unit_len;
      lat_sym    <= sym;
    end
  end

  // The tone sees live inputs at the accept edge, latched values afterwards.
  always_comb begin
    pwm_period = accept ? tone_period : lat_period;
    pwm_high   = accept ? tone_high   : lat_high;
  end

  tone_pwm #(.PW(PW)) u_tone (
    .clk     (clk),
    .rst     (rst),
    .restart (accept || !en),
    .gate    (next_state == ST_TONE),
    .period  (pwm_period),
    .high    (pwm_high),
    .beep    (beep)
  );

endmodule

// File: tb/tb_morse_tone_gen.sv
// Directed self-checking bench for morse_tone_gen.
module tb_morse_tone_gen;

  localparam int unsigned PW = 20;
  localparam int unsigned UW = 24;

  logic          clk;
  logic          rst;
  logic          en;
  logic [PW-1:0] tone_period;
  logic [PW-1:0] tone_high;
  logic [UW-1:0] unit_len;
  logic          sym_valid;
  logic [1:0]    sym;
  logic          sym_ready;
  logic          beep;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  morse_tone_gen #(.PW(PW), .UW(UW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .tone_period (tone_period),
    .tone_high   (tone_high),
    .unit_len    (unit_len),
    .sym_valid   (sym_valid),
    .sym         (sym),
    .sym_ready   (sym_ready),
    .beep        (beep),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a symbol at a negedge, wait for ready, return just after the accept edge.
  task automatic send(input logic [1:0] s, input bit hold);
    int budget;
    @(negedge clk);
    sym = s;
    sym_valid = 1'b1;
    budget = 200;
    while (!sym_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("ready_timeout", 32'(sym_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) sym_valid = 1'b0;
  endtask

  // Dot with period 4, high 2, U=8: 1100 1100 then 8 silent cycles.
  task automatic run_dot(input string tag);
    tone_period = 4; tone_high = 2; unit_len = 8;
    send(2'd0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk({tag, "_beep"}, 32'(beep), (i <= 8) ? 32'(((i - 1) % 4) < 2) : 32'd0);
      chk({tag, "_done"}, 32'(done), 32'(i == 16));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_rdy"},  32'(sym_ready), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_rdy_after"},  32'(sym_ready), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sym_valid = 1'b0; sym = 2'd0;
    tone_period = 4; tone_high = 2; unit_len = 8;

    // Reset state.
    #3;
    chk("rst_beep", 32'(beep), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdy",  32'(sym_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 32'(sym_ready), 32'd1);

    // Basic dot.
    run_dot("dot");

    // Dash then word gap back-to-back with valid held.
    tone_period = 4; tone_high = 2; unit_len = 8;
    send(2'd1, 1'b1);
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      chk("b2b_beep", 32'(beep), (i <= 24) ? 32'(((i - 1) % 4) < 2) : 32'd0);
      chk("b2b_done", 32'(done), 32'(i == 32 || i == 89));
      chk("b2b_rdy",  32'(sym_ready), 32'(i == 33 || i == 90));
      chk("b2b_busy", 32'(busy), 32'(i != 33 && i != 90));
      if (i == 1) sym = 2'd3;
      if (i == 34) sym_valid = 1'b0;
    end

    // high >= period: continuous tone for one unit.
    tone_period = 4; tone_high = 5; unit_len = 4;
    send(2'd0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("hi_ge_per_beep", 32'(beep), 32'(i <= 4));
      chk("hi_ge_per_done", 32'(done), 32'(i == 8));
    end

    // period 0: silent tone phase.
    tone_period = 0; tone_high = 2; unit_len = 4;
    send(2'd0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("per0_beep", 32'(beep), 32'd0);
      chk("per0_done", 32'(done), 32'(i == 8));
      chk("per0_busy", 32'(busy), 32'd1);
    end

    // unit_len 0 acts as 1: one tone cycle, one gap cycle.
    tone_period = 4; tone_high = 2; unit_len = 0;
    send(2'd0, 1'b0);
    @(negedge clk);
    chk("u0_beep1", 32'(beep), 32'd1);
    chk("u0_done1", 32'(done), 32'd0);
    @(negedge clk);
    chk("u0_beep2", 32'(beep), 32'd0);
    chk("u0_done2", 32'(done), 32'd1);
    @(negedge clk);
    chk("u0_rdy",   32'(sym_ready), 32'd1);

    // Config change mid-dash keeps the latched 4-cycle period.
    tone_period = 4; tone_high = 2; unit_len = 4;
    send(2'd1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("cfg_beep", 32'(beep), (i <= 12) ? 32'(((i - 1) % 4) < 2) : 32'd0);
      chk("cfg_done", 32'(done), 32'(i == 16));
      if (i == 5) begin tone_period = 10; tone_high = 7; unit_len = 9; end
    end
    tone_period = 4; tone_high = 2; unit_len = 4;
    @(negedge clk);

    // Abort a dash by dropping en in cycle 5.
    send(2'd1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("abort_beep_pre", 32'(beep), 32'(((i - 1) % 4) < 2));
    end
    en = 1'b0;
    #1;
    chk("abort_done_now", 32'(done), 32'd0);
    for (int i = 6; i <= 20; i++) begin
      @(negedge clk);
      chk("abort_beep", 32'(beep), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_rdy",  32'(sym_ready), 32'd0);
    end
    en = 1'b1;
    #1;
    chk("abort_rdy_en", 32'(sym_ready), 32'd1);

    // Async reset mid-tone, between edges.
    tone_period = 4; tone_high = 2; unit_len = 8;
    send(2'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("arst_beep_pre", 32'(beep), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_beep", 32'(beep), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_rdy",  32'(sym_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("arst_hold_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    run_dot("dot_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
